gate_test_sequencer: RTL and testbench

//   Self-test controller for the lab combinational gate unit (c=a&b, f=d|e, h=~g).
//   On start, drives all 32 input vectors in order and holds each for STEP_CYCLES clocks.

---
 rtl/gate_test_sequencer_pkg.sv | 7 +
 rtl/gate_test_sequencer_golden_model.sv | 11 +
 rtl/gate_test_sequencer.sv | 95 +++++++++
 tb/tb_gate_test_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gate_test_sequencer_pkg.sv
// gate_seq_pkg: shared state encoding and sizes for the gate unit self-test sequencer
package gate_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NUM_VEC = 32;
    localparam int VEC_W   = 5;
    localparam int ERR_W   = 6;
endpackage

// File: rtl/gate_test_sequencer_golden_model.sv
// gate_golden_model: reference response of the gate unit (c=a&b, f=d|e, h=~g)
//   vec      in  5  {g,e,d,b,a}
//   expected out 3  {h,f,c}
module gate_golden_model
    import gate_seq_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [2:0]       expected
);
    always_comb expected = {~vec[4], vec[2] | vec[3], vec[0] & vec[1]};
endmodule

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: steps the gate unit through all 32 vectors and scores its responses
//   clk, rst_n      clock, async active-low reset
//   start, pause    launch a run (IDLE/DONE), freeze counters (RUN)
//   gate_in         vector driven to the gate unit, {g,e,d,b,a}
//   gate_out        {h,f,c} returned by the gate unit
//   busy, done      run in progress, run finished
//   pass            no mismatches, valid with done
//   err_count       mismatching vectors, 0..32
//   first_fail      first mismatching vector, 0 if none
//   fail_seen       at least one mismatch this run
module gate_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int TICK_W      = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    output logic [VEC_W-1:0] gate_in,
    input  logic [2:0]       gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_seen
);
    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [VEC_W-1:0]  vec;
    logic [2:0]        expected;
    logic              mism;
    logic              last_tick;

    gate_golden_model u_gold (.vec(vec), .expected(expected));

    // gate_in has been stable on vec for at least STEP_CYCLES-1 cycles when last_tick is high
    always_comb begin
        mism      = expected != gate_out;
        last_tick = tick == TICK_W'(STEP_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            tick       <= '0;
            gate_in    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            gate_in <= vec;
            if (state != RUN) begin
                if (start) begin
                    state      <= RUN;
                    vec        <= '0;
                    tick       <= '0;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    pass       <= 1'b0;
                    err_count  <= '0;
                    first_fail <= '0;
                    fail_seen  <= 1'b0;
                end
            end else if (!pause) begin
                if (last_tick) begin
                    tick <= '0;
                    if (mism) begin
                        err_count <= (err_count == ERR_W'(NUM_VEC)) ? err_count : err_count + 1'b1;
                        if (!fail_seen) begin
                            first_fail <= vec;
                            fail_seen  <= 1'b1;
                        end
                    end
                    if (vec == VEC_W'(NUM_VEC - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mism;
                    end else begin
                        vec <= vec + 1'b1;
                    end
                end else begin
                    tick <= tick + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: scoreboard bench for gate_test_sequencer with a faultable gate unit
module tb_gate_test_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, start, pause;
    logic [4:0] gate_in, first_fail;
    logic [2:0] gate_out;
    logic       busy, done, pass, fail_seen;
    logic [5:0] err_count;

    bit         stuck_f0, h_as_g;
    logic [2:0] rmask [32];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {int err; int first; int pass; int fs; int dcyc;} exp_t;
    exp_t q[$];

    gate_test_sequencer #(.STEP_CYCLES(4), .TICK_W(27)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .gate_in(gate_in),
        .gate_out(gate_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail), .fail_seen(fail_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [2:0] good(input logic [4:0] v);
        return {~v[4], v[2] | v[3], v[0] & v[1]};
    endfunction

    function automatic logic [2:0] unit(input logic [4:0] v);
        logic [2:0] o;
        o = good(v);
        if (stuck_f0) o[1] = 1'b0;
        if (h_as_g) o[2] = v[4];
        return o ^ rmask[v];
    endfunction

    always_comb gate_out = unit(gate_in);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gate_in"}, gate_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_fail"}, first_fail, 0);
        chk({tag, "_fail_seen"}, fail_seen, 0);
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_err_clear", err_count, 0);
        chk("start_done_low", done, 0);
    endtask

    task automatic run(input bit pz, input bit rp);
        exp_t e;
        int   s, n, k;
        bit   stable;
        logic [4:0] g0;
        n = 0;
        e.first = 0;
        for (int v = 0; v < 32; v++)
            if (unit(5'(v)) != good(5'(v))) begin
                if (n == 0) e.first = v;
                n++;
            end
        e.err  = n;
        e.pass = (n == 0);
        e.fs   = (n != 0);
        pulse_start(s);
        e.dcyc = s + 1 + 32 * 4 + (pz ? 10 : 0);
        q.push_back(e);
        if (rp) begin
            repeat (59) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (pz) begin
            k = 0;
            while (gate_in != 5'd7 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("pause_reach_vec7", gate_in, 7);
            pause = 1'b1;
            g0 = gate_in;
            stable = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (gate_in != g0) stable = 1'b0;
            end
            pause = 1'b0;
            chk("pause_gate_in_const", stable, 1);
        end
        k = 0;
        while (q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("run_completed", q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        bit   dq = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !dq) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done rose at cycle %0d with no run pending", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.dcyc);
                    chk("err_count", err_count, e.err);
                    chk("first_fail", first_fail, e.first);
                    chk("pass", pass, e.pass);
                    chk("fail_seen", fail_seen, e.fs);
                    chk("busy_at_done", busy, 0);
                end
            end
            dq = done;
        end
    end

    initial begin : stim
        int s;
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stuck_f0 = 1'b0;
        h_as_g = 1'b0;
        for (int v = 0; v < 32; v++) rmask[v] = 3'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(1'b0, 1'b0);
        stuck_f0 = 1'b1;
        run(1'b0, 1'b0);
        stuck_f0 = 1'b0;
        h_as_g = 1'b1;
        run(1'b0, 1'b0);
        h_as_g = 1'b0;
        run(1'b1, 1'b0);
        run(1'b0, 1'b1);

        pulse_start(s);
        repeat (48) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < 32; v++)
                rmask[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
            run(r[0], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
